// File: rtl/usb_spi_pkg.sv
// Shared types for the multi-channel SPI master: FSM state encoding and the
// per-transfer {CPOL,CPHA} mode pair.
package usb_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HELD,
    HOLD,
    GAP
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of a select index; a single-slave build still needs one bit.
  function automatic int ss_width(input int num_ss);
    return (num_ss > 1) ? $clog2(num_ss) : 1;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: pulses tick once every CLK_DIV enabled cycles and
// restarts a full half-period each time enable rises.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == LAST);

  // Held at the reload value while disabled, so every enable rise starts a
  // complete half-period; the count never wraps except through this reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/usb_spi_master_mc.sv
// Multi-channel SPI master: command/response handshake, per-command mode,
// chip-select bursts with implicit close on a select change.
module usb_spi_master_mc
  import usb_spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 2,
  parameter int CLK_DIV = 4,
  parameter int SS_W    = ss_width(NUM_SS)
) (
  input  logic              Clk,
  input  logic              reset_rtl_0,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [SS_W-1:0]   cmd_ss,
  input  logic [1:0]        cmd_mode,
  input  logic              cmd_last,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_SS-1:0] spi_ss_n
);

  localparam int HW = $clog2(2 * DATA_W + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);

  spi_state_t state_reg, state_next;

  spi_mode_t         mode_reg;
  logic [SS_W-1:0]   ss_reg;
  logic              last_reg;
  logic              err_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [HW-1:0]     half_reg;
  logic              done_reg;

  logic              pend_reg;
  logic [DATA_W-1:0] pend_data_reg;
  logic [SS_W-1:0]   pend_ss_reg;
  spi_mode_t         pend_mode_reg;
  logic              pend_last_reg;

  logic              sclk_reg;
  logic              mosi_reg;
  logic [NUM_SS-1:0] ss_n_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_err_reg;

  logic              tick_en;
  logic              tick;
  logic              accept;
  logic              same_ss;
  logic              load_setup;
  logic              load_shift;
  logic              close_req;
  logic              shift_tick;
  logic              shift_edge;
  logic              sample_edge;
  logic              last_half;

  logic [DATA_W-1:0] src_data;
  logic [SS_W-1:0]   src_ss;
  spi_mode_t         src_mode;
  logic              src_last;
  logic              src_err;
  logic [NUM_SS-1:0] ss_dec;

  spi_half_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_half_tick (
    .clk  (Clk),
    .rst_n(reset_rtl_0),
    .en   (tick_en),
    .tick (tick)
  );

  // A command deferred by an implicit close is replayed from the pending
  // registers when GAP ends; every other load takes the live command.
  assign src_data = (state_reg == GAP) ? pend_data_reg : cmd_data;
  assign src_ss   = (state_reg == GAP) ? pend_ss_reg   : cmd_ss;
  assign src_mode = (state_reg == GAP) ? pend_mode_reg : spi_mode_t'(cmd_mode);
  assign src_last = (state_reg == GAP) ? pend_last_reg : cmd_last;
  assign src_err  = (int'(src_ss) >= NUM_SS);

  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
    assign ss_dec[gi] = (src_ss != SS_W'(gi));
  end

  assign accept     = cmd_valid && cmd_ready;
  assign same_ss    = (cmd_ss == ss_reg);
  assign load_setup = ((state_reg == IDLE) && accept) ||
                      ((state_reg == GAP) && tick && pend_reg);
  assign load_shift = (state_reg == HELD) && accept && same_ss;
  assign close_req  = (state_reg == HELD) && accept && !same_ss;

  // Even half-periods end on the leading SCLK edge; CPHA picks which of the
  // two edges samples MISO and which advances MOSI.
  assign shift_tick  = (state_reg == SHIFT) && tick;
  assign shift_edge  = shift_tick && (half_reg[0] != mode_reg.cpha);
  assign sample_edge = shift_tick && (half_reg[0] == mode_reg.cpha);
  assign last_half   = shift_tick && (half_reg == HALF_LAST);

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   if (tick) state_next = SHIFT;
      SHIFT:   if (last_half) state_next = last_reg ? HOLD : HELD;
      HELD:    if (cmd_valid) state_next = same_ss ? SHIFT : HOLD;
      HOLD:    if (tick) state_next = GAP;
      GAP:     if (tick) state_next = pend_reg ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_reg == IDLE) || (state_reg == HELD);
    busy      = (state_reg != IDLE);
    tick_en   = (state_reg == SETUP) || (state_reg == SHIFT) ||
                (state_reg == HOLD)  || (state_reg == GAP);
  end

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      mode_reg      <= '0;
      ss_reg        <= '0;
      last_reg      <= 1'b0;
      err_reg       <= 1'b0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      half_reg      <= '0;
      done_reg      <= 1'b0;
      pend_reg      <= 1'b0;
      pend_data_reg <= '0;
      pend_ss_reg   <= '0;
      pend_mode_reg <= '0;
      pend_last_reg <= 1'b0;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      ss_n_reg      <= '1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      // The last sample lands on the final half-period; the response is
      // published one cycle later from the completed receive register.
      done_reg      <= last_half;
      rsp_valid_reg <= done_reg;
      rsp_err_reg   <= done_reg && err_reg;
      if (done_reg) begin
        rsp_data_reg <= rx_reg;
      end

      if (state_reg != SHIFT) begin
        half_reg <= '0;
      end else if (tick) begin
        half_reg <= half_reg + 1'b1;
      end

      if (shift_tick) begin
        sclk_reg <= ~sclk_reg;
      end
      if (sample_edge) begin
        rx_reg <= {rx_reg[DATA_W-2:0], spi_miso};
      end
      if (shift_edge) begin
        mosi_reg <= tx_reg[DATA_W-1];
        tx_reg   <= tx_reg << 1;
      end

      if (load_setup) begin
        ss_reg   <= src_ss;
        mode_reg <= src_mode;
        last_reg <= src_last;
        err_reg  <= src_err;
        sclk_reg <= src_mode.cpol;
        ss_n_reg <= ss_dec;
        if (!src_mode.cpha) begin
          mosi_reg <= src_data[DATA_W-1];
          tx_reg   <= src_data << 1;
        end else begin
          tx_reg   <= src_data;
        end
        if (state_reg == GAP) begin
          pend_reg <= 1'b0;
        end
      end

      // Continuing a burst keeps the select and mode already in force.
      if (load_shift) begin
        last_reg <= cmd_last;
        if (!mode_reg.cpha) begin
          mosi_reg <= cmd_data[DATA_W-1];
          tx_reg   <= cmd_data << 1;
        end else begin
          tx_reg   <= cmd_data;
        end
      end

      if (close_req) begin
        pend_reg      <= 1'b1;
        pend_data_reg <= cmd_data;
        pend_ss_reg   <= cmd_ss;
        pend_mode_reg <= spi_mode_t'(cmd_mode);
        pend_last_reg <= cmd_last;
      end

      if ((state_reg == HOLD) && tick) begin
        ss_n_reg <= '1;
      end
    end
  end

  assign spi_sclk  = sclk_reg;
  assign spi_mosi  = mosi_reg;
  assign spi_ss_n  = ss_n_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_usb_spi_master_mc.sv
// Directed bench for usb_spi_master_mc: a two-select build with MOSI looped to
// MISO, plus a single-select build for the out-of-range select case.
module tb_usb_spi_master_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         checks = 0;
  int         errors = 0;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_ss;
  logic [1:0] cmd_mode;
  logic       cmd_last;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [1:0] spi_ss_n;
  logic       miso_tie;

  logic       b_cmd_valid;
  logic       b_cmd_ready;
  logic [7:0] b_cmd_data;
  logic       b_cmd_ss;
  logic [1:0] b_cmd_mode;
  logic       b_cmd_last;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_data;
  logic       b_rsp_err;
  logic       b_busy;
  logic       b_spi_sclk;
  logic       b_spi_mosi;
  logic       b_spi_miso;
  logic [0:0] b_spi_ss_n;

  assign spi_miso   = miso_tie ? 1'b1 : spi_mosi;
  assign b_spi_miso = b_spi_mosi;

  usb_spi_master_mc #(.DATA_W(8), .NUM_SS(2), .CLK_DIV(2)) dut (
    .Clk(clk), .reset_rtl_0(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_ss(cmd_ss), .cmd_mode(cmd_mode), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss_n(spi_ss_n)
  );

  usb_spi_master_mc #(.DATA_W(8), .NUM_SS(1), .CLK_DIV(2)) dut_one (
    .Clk(clk), .reset_rtl_0(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_data(b_cmd_data),
    .cmd_ss(b_cmd_ss), .cmd_mode(b_cmd_mode), .cmd_last(b_cmd_last),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err), .busy(b_busy),
    .spi_sclk(b_spi_sclk), .spi_mosi(b_spi_mosi), .spi_miso(b_spi_miso), .spi_ss_n(b_spi_ss_n)
  );

  // Called on a falling edge; returns #1 after the accepting rising edge.
  task automatic send_cmd(input logic [7:0] d, input logic ss, input logic [1:0] m,
                          input logic l, output bit ok);
    ok = 1'b0;
    cmd_data = d; cmd_ss = ss; cmd_mode = m; cmd_last = l; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
  endtask

  // Cycle k is the k-th falling edge after the accept edge (k=0 first).
  task automatic wait_rsp(input logic [1:0] exp_ss_n, output int lat, output logic [7:0] data,
                          output logic err, output int rises, output bit ss_ok, output bit got);
    logic prev;
    got = 1'b0; lat = -1; data = '0; err = 1'b0; rises = 0; ss_ok = 1'b1;
    prev = spi_sclk;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
      if (spi_ss_n !== exp_ss_n) ss_ok = 1'b0;
      if (rsp_valid) begin
        got = 1'b1; lat = k; data = rsp_data; err = rsp_err;
        break;
      end
    end
    $display("txn ss_n=%b rsp=%h err=%0d latency=%0d sclk_rises=%0d", exp_ss_n, data, err, lat, rises);
  endtask

  task automatic wait_idle(output bit idle);
    idle = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) begin idle = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    checks++; if (spi_ss_n !== 2'b11) begin errors++; $display("FAIL reset_ss_n: got %b want 11", spi_ss_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_mode0;
    bit ok, got, ss_ok, idle; int lat, rises; logic [7:0] d; logic e;
    send_cmd(8'hA5, 1'b0, 2'b00, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL m0_accept: got 0 want 1"); end
    wait_rsp(2'b10, lat, d, e, rises, ss_ok, got);
    checks++; if (lat != 35) begin errors++; $display("FAIL m0_latency: got %0d want 35", lat); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL m0_data: got %h want a5", d); end
    checks++; if (rises != 8) begin errors++; $display("FAIL m0_sclk_rises: got %0d want 8", rises); end
    checks++; if (!ss_ok) begin errors++; $display("FAIL m0_ss_held: got 0 want 1"); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL m0_err: got %b want 0", e); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL m0_pulse_width: got %b want 0", rsp_valid); end
    wait_idle(idle);
    checks++; if (!idle) begin errors++; $display("FAIL m0_idle_timeout: got busy %b want 0", busy); end
    checks++; if (spi_ss_n !== 2'b11) begin errors++; $display("FAIL m0_ss_release: got %b want 11", spi_ss_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL m0_sclk_idle: got %b want 0", spi_sclk); end
  endtask

  task automatic test_mode3;
    bit ok, got, ss_ok, idle; int lat, rises; logic [7:0] d; logic e;
    miso_tie = 1'b1;
    send_cmd(8'h3C, 1'b1, 2'b11, 1'b1, ok);
    checks++; if (spi_sclk !== 1'b1) begin errors++; $display("FAIL m3_sclk_cpol: got %b want 1", spi_sclk); end
    wait_rsp(2'b01, lat, d, e, rises, ss_ok, got);
    checks++; if (lat != 35) begin errors++; $display("FAIL m3_latency: got %0d want 35", lat); end
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL m3_data: got %h want ff", d); end
    checks++; if (!ss_ok) begin errors++; $display("FAIL m3_ss_held: got 0 want 1"); end
    checks++; if (rises != 8) begin errors++; $display("FAIL m3_sclk_rises: got %0d want 8", rises); end
    wait_idle(idle);
    checks++; if (spi_sclk !== 1'b1) begin errors++; $display("FAIL m3_sclk_idle: got %b want 1", spi_sclk); end
    checks++; if (spi_ss_n !== 2'b11) begin errors++; $display("FAIL m3_ss_release: got %b want 11", spi_ss_n); end
    miso_tie = 1'b0;
  endtask

  task automatic test_burst;
    logic [7:0] words [3] = '{8'h01, 8'h02, 8'h03};
    int         lats  [3] = '{35, 33, 33};
    bit ok, got, ss_ok; int lat, rises, deasserts; logic [7:0] d; logic e; logic [1:0] prev_ss;
    for (int i = 0; i < 3; i++) begin
      send_cmd(words[i], 1'b0, 2'b00, (i == 2), ok);
      wait_rsp(2'b10, lat, d, e, rises, ss_ok, got);
      checks++; if (lat != lats[i]) begin errors++; $display("FAIL burst_latency[%0d]: got %0d want %0d", i, lat, lats[i]); end
      checks++; if (d !== words[i]) begin errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, d, words[i]); end
      checks++; if (!ss_ok) begin errors++; $display("FAIL burst_ss_held[%0d]: got 0 want 1", i); end
    end
    deasserts = 0;
    prev_ss = spi_ss_n;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (prev_ss == 2'b10 && spi_ss_n == 2'b11) deasserts++;
      prev_ss = spi_ss_n;
      if (!busy) break;
    end
    checks++; if (deasserts != 1) begin errors++; $display("FAIL burst_deasserts: got %0d want 1", deasserts); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle: got %b want 0", busy); end
  endtask

  task automatic test_switch;
    bit ok, got, ss_ok, seen01, idle; int lat, rises, gap; logic [7:0] d; logic e; logic [1:0] first_ss;
    send_cmd(8'h55, 1'b0, 2'b00, 1'b0, ok);
    wait_rsp(2'b10, lat, d, e, rises, ss_ok, got);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL sw_first_data: got %h want 55", d); end
    send_cmd(8'h66, 1'b1, 2'b01, 1'b1, ok);
    gap = 0; seen01 = 1'b0; got = 1'b0; lat = -1; first_ss = 2'bxx; d = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) first_ss = spi_ss_n;
      if (!seen01) begin
        if (spi_ss_n == 2'b11) gap++;
        else if (spi_ss_n == 2'b01) seen01 = 1'b1;
      end
      if (rsp_valid) begin got = 1'b1; lat = k; d = rsp_data; break; end
    end
    $display("txn ss_n=01 rsp=%h latency=%0d gap=%0d", d, lat, gap);
    checks++; if (first_ss !== 2'b10) begin errors++; $display("FAIL sw_hold_old_ss: got %b want 10", first_ss); end
    checks++; if (gap < 2) begin errors++; $display("FAIL sw_gap_cycles: got %0d want >=2", gap); end
    checks++; if (!seen01) begin errors++; $display("FAIL sw_new_ss: got 0 want 1"); end
    checks++; if (lat != 39) begin errors++; $display("FAIL sw_latency: got %0d want 39", lat); end
    checks++; if (d !== 8'h66) begin errors++; $display("FAIL sw_data: got %h want 66", d); end
    wait_idle(idle);
    checks++; if (spi_ss_n !== 2'b11) begin errors++; $display("FAIL sw_release: got %b want 11", spi_ss_n); end
  endtask

  task automatic test_oor;
    bit got, ss_bad; int lat; logic e; logic [7:0] d;
    b_cmd_data = 8'hA5; b_cmd_ss = 1'b1; b_cmd_mode = 2'b00; b_cmd_last = 1'b1; b_cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (b_cmd_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 b_cmd_valid = 1'b0;
    got = 1'b0; ss_bad = 1'b0; lat = -1; e = 1'b0; d = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b_spi_ss_n !== 1'b1) ss_bad = 1'b1;
      if (b_rsp_valid) begin got = 1'b1; lat = k; e = b_rsp_err; d = b_rsp_data; break; end
    end
    $display("txn oor ss=1 rsp=%h err=%0d latency=%0d", d, e, lat);
    checks++; if (!got) begin errors++; $display("FAIL oor_rsp_valid: got 0 want 1"); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rsp_err: got %b want 1", e); end
    checks++; if (ss_bad) begin errors++; $display("FAIL oor_ss_asserted: got 1 want 0"); end
    checks++; if (lat != 35) begin errors++; $display("FAIL oor_latency: got %0d want 35", lat); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL oor_data: got %h want a5", d); end
    @(negedge clk);
    checks++; if (b_rsp_err !== 1'b0) begin errors++; $display("FAIL oor_err_width: got %b want 0", b_rsp_err); end
  endtask

  task automatic test_reset_mid;
    bit ok, got, ss_ok, seen_rv, idle; int lat, rises; logic [7:0] d; logic e;
    send_cmd(8'hC3, 1'b0, 2'b00, 1'b1, ok);
    for (int k = 0; k < 21; k++) @(negedge clk);
    checks++; if (spi_ss_n !== 2'b10 || spi_sclk !== 1'b1) begin errors++; $display("FAIL rm_pre_state: got ss_n %b sclk %b want 10 1", spi_ss_n, spi_sclk); end
    rst_n = 1'b0;
    #1;
    checks++; if (spi_ss_n !== 2'b11) begin errors++; $display("FAIL rm_ss_n: got %b want 11", spi_ss_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rm_sclk: got %b want 0", spi_sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    seen_rv = 1'b0;
    for (int k = 0; k < 2; k++) begin @(negedge clk); if (rsp_valid) seen_rv = 1'b1; end
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin @(negedge clk); if (rsp_valid) seen_rv = 1'b1; end
    checks++; if (seen_rv) begin errors++; $display("FAIL rm_no_rsp: got 1 want 0"); end
    send_cmd(8'h96, 1'b0, 2'b00, 1'b1, ok);
    wait_rsp(2'b10, lat, d, e, rises, ss_ok, got);
    checks++; if (lat != 35) begin errors++; $display("FAIL rm_next_latency: got %0d want 35", lat); end
    checks++; if (d !== 8'h96) begin errors++; $display("FAIL rm_next_data: got %h want 96", d); end
    wait_idle(idle);
    checks++; if (spi_ss_n !== 2'b11) begin errors++; $display("FAIL rm_next_release: got %b want 11", spi_ss_n); end
  endtask

  initial begin
    rst_n = 1'b0; miso_tie = 1'b0;
    cmd_valid = 1'b0; cmd_data = '0; cmd_ss = 1'b0; cmd_mode = 2'b00; cmd_last = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_data = '0; b_cmd_ss = 1'b0; b_cmd_mode = 2'b00; b_cmd_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_mode0;
    test_mode3;
    test_burst;
    test_switch;
    test_oor;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
